droplet_mux_sequencer: RTL and testbench

- Digital controller for an N-channel droplet-generator/mixer front end that feeds one multiplexer into a single long cell trap.
- Arbitrates channel requests and drives the mux control valves one-hot, with break-before-make dead time.
- Confirms each delivered droplet and counts trap occupancy, blocking further loads at capacity until cleared.
- Generalises the fixed two-input, two-control-line arrangement to N channels, selectable arbitration, timeouts and occupancy tracking.

---
 rtl/droplet_ctrl_pkg.sv | 23 ++
 rtl/droplet_arbiter.sv | 47 ++++
 rtl/droplet_mux_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_droplet_mux_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/droplet_ctrl_pkg.sv
// Shared types and helpers for the droplet mux sequencer: FSM state encoding,
// arbitration mode constants and an index-to-one-hot helper.
package droplet_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        DISPENSE = 2'd2,
        FULL     = 2'd3
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int MAX_CH    = 16;

    function automatic logic [MAX_CH-1:0] onehot_from_idx(input logic [3:0] idx);
        logic [MAX_CH-1:0] oh;
        oh      = {MAX_CH{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/droplet_arbiter.sv
// Combinational channel arbiter: fixed priority (lowest index) or round-robin
// starting at the supplied pointer and wrapping past the top channel.
module droplet_arbiter
    import droplet_ctrl_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int MODE  = ARB_FIXED,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] start_s;

    assign start_s = (MODE == ARB_RR) ? ptr : {IDX_W{1'b0}};

    // Scan upward from start_s, wrapping, and take the first active request
    always_comb begin
        logic [IDX_W-1:0] cand;
        int               pos;
        valid = 1'b0;
        idx   = {IDX_W{1'b0}};
        cand  = {IDX_W{1'b0}};
        pos   = 0;
        for (int i = 0; i < N_CH; i++) begin
            pos  = int'(start_s) + i;
            pos  = (pos >= N_CH) ? (pos - N_CH) : pos;
            cand = IDX_W'(pos);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end else begin
                idx   = idx;
            end
        end
        if (valid) begin
            onehot = N_CH'(onehot_from_idx(4'(idx)));
        end else begin
            onehot = {N_CH{1'b0}};
        end
    end

endmodule

// File: rtl/droplet_mux_sequencer.sv
// N-channel droplet mux sequencer: arbitrates requests, opens one valve at a time
// with break-before-make dead time, confirms droplets and tracks trap occupancy.
module droplet_mux_sequencer
    import droplet_ctrl_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int MODE       = ARB_FIXED,
    parameter int SETTLE_CYC = 3,
    parameter int DWELL_MAX  = 16,
    parameter int TRAP_DEPTH = 4,
    parameter int CNT_W      = $clog2(TRAP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             droplet_sense,
    input  logic             clear,
    output logic [N_CH-1:0]  valve,
    output logic             trap_valve,
    output logic [N_CH-1:0]  grant,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             busy
);

    localparam int IDX_W = $clog2(N_CH);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int DW_W  = $clog2(DWELL_MAX + 1);

    localparam logic [CNT_W-1:0] TRAP_CNT = CNT_W'(TRAP_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TRAP_DEPTH - 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL_MAX - 1);
    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(N_CH - 1);

    state_t           state_r, state_s;
    logic [IDX_W-1:0] sel_r, sel_s, ptr_r, ptr_s, ptr_adv_s, arb_idx_s;
    logic [N_CH-1:0]  sel_oh_r, sel_oh_s, arb_oh_s;
    logic             arb_valid_s;
    logic [SET_W-1:0] settle_r, settle_s;
    logic [DW_W-1:0]  dwell_r, dwell_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             droplet_s, expire_s;

    logic [N_CH-1:0]  valve_s, valve_r, grant_r;
    logic             trap_s, trap_r, busy_s, busy_r, full_s, full_r, done_r, timeout_r;

    droplet_arbiter #(
        .N_CH  (N_CH),
        .MODE  (MODE),
        .IDX_W (IDX_W)
    ) u_arbiter (
        .req    (req),
        .ptr    (ptr_r),
        .onehot (arb_oh_s),
        .idx    (arb_idx_s),
        .valid  (arb_valid_s)
    );

    assign ptr_adv_s = (sel_r == LAST_CH) ? {IDX_W{1'b0}} : (sel_r + IDX_W'(1));

    // State, selection, pointer, timers and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            sel_r    <= {IDX_W{1'b0}};
            sel_oh_r <= {N_CH{1'b0}};
            ptr_r    <= {IDX_W{1'b0}};
            settle_r <= {SET_W{1'b0}};
            dwell_r  <= {DW_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            sel_r    <= sel_s;
            sel_oh_r <= sel_oh_s;
            ptr_r    <= ptr_s;
            settle_r <= settle_s;
            dwell_r  <= dwell_s;
            count_r  <= count_s;
        end
    end

    // Next-state logic; a droplet beats both an aborting request drop and the dwell timeout
    always_comb begin
        state_s   = state_r;
        sel_s     = sel_r;
        sel_oh_s  = sel_oh_r;
        ptr_s     = ptr_r;
        settle_s  = settle_r;
        dwell_s   = dwell_r;
        droplet_s = 1'b0;
        expire_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (arb_valid_s && (count_r < TRAP_CNT)) begin
                    state_s  = SETTLE;
                    sel_s    = arb_idx_s;
                    sel_oh_s = arb_oh_s;
                    settle_s = SET_LOAD;
                end else begin
                    state_s  = IDLE;
                end
            end
            SETTLE: begin
                if (!req[sel_r]) begin
                    state_s = IDLE;
                end else if (settle_r == {SET_W{1'b0}}) begin
                    state_s = DISPENSE;
                    dwell_s = {DW_W{1'b0}};
                end else begin
                    settle_s = settle_r - SET_W'(1);
                end
            end
            DISPENSE: begin
                if (droplet_sense) begin
                    droplet_s = 1'b1;
                    ptr_s     = ptr_adv_s;
                    if (!clear && (count_r == LAST_CNT)) begin
                        state_s = FULL;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (!req[sel_r]) begin
                    state_s = IDLE;
                end else if (dwell_r == DW_LAST) begin
                    expire_s = 1'b1;
                    ptr_s    = ptr_adv_s;
                    state_s  = IDLE;
                end else begin
                    dwell_s = dwell_r + DW_W'(1);
                end
            end
            FULL: begin
                if (clear) begin
                    state_s = IDLE;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Occupancy: clear wins over a same-cycle increment; saturates at capacity
    always_comb begin
        if (clear) begin
            count_s = {CNT_W{1'b0}};
        end else if (droplet_s && (count_r != TRAP_CNT)) begin
            count_s = count_r + CNT_W'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Output decode from the next state so valves are only open while in DISPENSE
    always_comb begin
        if (state_s == DISPENSE) begin
            valve_s = sel_oh_s;
            trap_s  = 1'b1;
        end else begin
            valve_s = {N_CH{1'b0}};
            trap_s  = 1'b0;
        end
        busy_s = (state_s == SETTLE) || (state_s == DISPENSE);
        full_s = (count_s == TRAP_CNT);
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valve_r   <= {N_CH{1'b0}};
            grant_r   <= {N_CH{1'b0}};
            trap_r    <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            full_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            valve_r   <= valve_s;
            grant_r   <= valve_s;
            trap_r    <= trap_s;
            done_r    <= droplet_s;
            timeout_r <= expire_s;
            full_r    <= full_s;
            busy_r    <= busy_s;
        end
    end

    assign valve      = valve_r;
    assign grant      = grant_r;
    assign trap_valve = trap_r;
    assign done       = done_r;
    assign timeout    = timeout_r;
    assign count      = count_r;
    assign full       = full_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_droplet_mux_sequencer.sv
// Self-checking bench: a round-robin and a fixed-priority instance share stimulus;
// table-driven vectors cover latency/timeout, hand sequences cover the corner cases.
module tb_droplet_mux_sequencer;

    localparam int N  = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic          droplet_sense;
    logic          clear;

    logic [N-1:0]  rr_valve, rr_grant, fp_valve, fp_grant;
    logic          rr_trap, rr_done, rr_tmo, rr_full, rr_busy;
    logic          fp_trap, fp_done, fp_tmo, fp_full, fp_busy;
    logic [CW-1:0] rr_count, fp_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] req;
        logic       ds;
        logic       clr;
        logic [3:0] valve;
        logic       trap;
        logic       done;
        logic       tmo;
        logic [2:0] count;
        logic       full;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    droplet_mux_sequencer #(.N_CH(4), .MODE(1), .SETTLE_CYC(3), .DWELL_MAX(16), .TRAP_DEPTH(4)) u_rr (
        .clk(clk), .rst(rst), .req(req), .droplet_sense(droplet_sense), .clear(clear),
        .valve(rr_valve), .trap_valve(rr_trap), .grant(rr_grant), .done(rr_done),
        .timeout(rr_tmo), .count(rr_count), .full(rr_full), .busy(rr_busy)
    );

    droplet_mux_sequencer #(.N_CH(4), .MODE(0), .SETTLE_CYC(3), .DWELL_MAX(16), .TRAP_DEPTH(4)) u_fp (
        .clk(clk), .rst(rst), .req(req), .droplet_sense(droplet_sense), .clear(clear),
        .valve(fp_valve), .trap_valve(fp_trap), .grant(fp_grant), .done(fp_done),
        .timeout(fp_tmo), .count(fp_count), .full(fp_full), .busy(fp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic ds, input logic clr, input logic [3:0] v,
                       input logic trap, input logic dn, input logic tmo, input logic [2:0] cnt,
                       input logic fl, input logic bz);
        vec_t e;
        e.req = r; e.ds = ds; e.clr = clr; e.valve = v; e.trap = trap;
        e.done = dn; e.tmo = tmo; e.count = cnt; e.full = fl; e.busy = bz;
        vecs.push_back(e);
    endtask

    // Each row: check outputs of the current cycle, then drive that cycle's inputs
    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            tick();
            chk4($sformatf("%s[%0d] valve", tag, i), rr_valve, vecs[i].valve);
            chk4($sformatf("%s[%0d] grant", tag, i), rr_grant, vecs[i].valve);
            chk4($sformatf("%s[%0d] fp_valve", tag, i), fp_valve, vecs[i].valve);
            chk1($sformatf("%s[%0d] trap_valve", tag, i), rr_trap, vecs[i].trap);
            chk1($sformatf("%s[%0d] done", tag, i), rr_done, vecs[i].done);
            chk1($sformatf("%s[%0d] timeout", tag, i), rr_tmo, vecs[i].tmo);
            chk3($sformatf("%s[%0d] count", tag, i), rr_count, vecs[i].count);
            chk1($sformatf("%s[%0d] full", tag, i), rr_full, vecs[i].full);
            chk1($sformatf("%s[%0d] busy", tag, i), rr_busy, vecs[i].busy);
            req           = vecs[i].req;
            droplet_sense = vecs[i].ds;
            clear         = vecs[i].clr;
        end
        vecs.delete();
    endtask

    task automatic do_reset(input string tag);
        req = 4'b0000; droplet_sense = 1'b0; clear = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk4({tag, " rst valve"}, rr_valve | fp_valve, 4'b0000);
        chk4({tag, " rst grant"}, rr_grant | fp_grant, 4'b0000);
        chk1({tag, " rst trap"}, rr_trap | fp_trap, 1'b0);
        chk1({tag, " rst pulses"}, rr_done | rr_tmo | fp_done | fp_tmo, 1'b0);
        chk3({tag, " rst count"}, rr_count | fp_count, 3'd0);
        chk1({tag, " rst full/busy"}, rr_full | rr_busy | fp_full | fp_busy, 1'b0);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick();
            seen = (rr_grant != 4'b0000);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s wait_grant: actual=no grant in 30 cycles required=grant", tag);
        end
    endtask

    // Grant, two dwell cycles, then a droplet; check grant identity and the done pulse
    task automatic serve(input string tag, input logic [3:0] exp_rr, input logic [3:0] exp_fp,
                         input logic [2:0] exp_cnt);
        wait_grant(tag);
        chk4({tag, " rr grant"}, rr_grant, exp_rr);
        chk4({tag, " rr valve"}, rr_valve, exp_rr);
        chk4({tag, " fp grant"}, fp_grant, exp_fp);
        tick();
        tick();
        droplet_sense = 1'b1;
        tick();
        droplet_sense = 1'b0;
        chk1({tag, " rr done"}, rr_done, 1'b1);
        chk1({tag, " fp done"}, fp_done, 1'b1);
        chk3({tag, " count"}, rr_count, exp_cnt);
        chk4({tag, " valve closed"}, rr_valve, 4'b0000);
    endtask

    logic [3:0] acc_g;
    logic       acc_b;

    initial begin
        rst = 1'b1; req = 4'b0000; droplet_sense = 1'b0; clear = 1'b0;

        // Latency and dead time
        do_reset("lat");
        for (int i = 0; i < 3; i++) add(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        add(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) add(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        add(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        run_table("lat");

        // Timeout after 16 DISPENSE cycles
        do_reset("tmo");
        add(4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  add(4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) add(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        run_table("tmo");

        // Round-robin to capacity, FULL blocking, clear, restart at channel 0
        do_reset("rr");
        req = 4'b1111;
        serve("rr0", 4'b0001, 4'b0001, 3'd1);
        serve("rr1", 4'b0010, 4'b0001, 3'd2);
        serve("rr2", 4'b0100, 4'b0001, 3'd3);
        serve("rr3", 4'b1000, 4'b0001, 3'd4);
        chk1("rr full", rr_full, 1'b1);
        chk1("fp full", fp_full, 1'b1);
        acc_g = 4'b0000; acc_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            acc_g = acc_g | rr_grant | rr_valve | fp_grant;
            acc_b = acc_b | rr_busy;
        end
        chk4("full no grant", acc_g, 4'b0000);
        chk1("full not busy", acc_b, 1'b0);
        chk3("full count held", rr_count, 3'd4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk3("clear count", rr_count, 3'd0);
        chk1("clear full", rr_full, 1'b0);
        serve("rr_after_clear", 4'b0001, 4'b0001, 3'd1);

        // Fixed priority versus round-robin on req=1010
        do_reset("fp");
        req = 4'b1010;
        serve("fp0", 4'b0010, 4'b0010, 3'd1);
        serve("fp1", 4'b1000, 4'b0010, 3'd2);
        serve("fp2", 4'b0010, 4'b0010, 3'd3);

        // Droplet on the last dwell cycle beats timeout; clear beats the increment
        do_reset("sim");
        req = 4'b0001;
        wait_grant("sim");
        for (int i = 0; i < 15; i++) tick();
        chk4("sim dwell16 open", rr_valve, 4'b0001);
        droplet_sense = 1'b1;
        tick();
        droplet_sense = 1'b0;
        chk1("sim done", rr_done, 1'b1);
        chk1("sim no timeout", rr_tmo, 1'b0);
        chk3("sim count", rr_count, 3'd1);
        wait_grant("simclr");
        droplet_sense = 1'b1;
        clear = 1'b1;
        tick();
        droplet_sense = 1'b0;
        clear = 1'b0;
        chk1("simclr done", rr_done, 1'b1);
        chk3("simclr count", rr_count, 3'd0);
        chk1("simclr full", rr_full, 1'b0);

        // Request withdrawn during SETTLE: no grant at all
        do_reset("abs");
        req = 4'b0100;
        tick();
        chk1("abs settling", rr_busy, 1'b1);
        tick();
        req = 4'b0000;
        tick();
        chk1("abs back idle", rr_busy, 1'b0);
        acc_g = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            acc_g = acc_g | rr_grant | fp_grant | rr_valve;
        end
        chk4("abs no grant", acc_g, 4'b0000);

        // Request withdrawn during DISPENSE: valve shuts, no pulses, count kept
        do_reset("abd");
        req = 4'b0100;
        wait_grant("abd");
        tick();
        req = 4'b0000;
        tick();
        chk4("abd valve", rr_valve, 4'b0000);
        chk1("abd trap", rr_trap, 1'b0);
        chk1("abd pulses", rr_done | rr_tmo, 1'b0);
        chk3("abd count", rr_count, 3'd0);
        acc_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            acc_b = acc_b | rr_tmo | rr_done;
        end
        chk1("abd no late pulse", acc_b, 1'b0);

        // Asynchronous reset in the middle of DISPENSE
        do_reset("arst");
        req = 4'b0100;
        serve("arst pre", 4'b0100, 4'b0100, 3'd1);
        wait_grant("arst");
        chk4("arst open before", rr_valve, 4'b0100);
        #1 rst = 1'b1;
        #1;
        chk4("arst valve", rr_valve | fp_valve, 4'b0000);
        chk1("arst trap", rr_trap, 1'b0);
        chk4("arst grant", rr_grant, 4'b0000);
        chk3("arst count", rr_count, 3'd0);
        req = 4'b0000;
        tick();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
